// File: rtl/symm_norm.sv
// Scales the 4x4 matrix W by 1/||W||_F (sum of squares, bit-serial sqrt, restoring divide); SYMM_NORM_ROUND_EN rounds quotients.
// Latency 279 edges from accept to done_norm (17 when S==0); no backpressure, start_norm ignored unless IDLE.
module symm_norm #(
   parameter int DW   = 26,
   parameter int FRAC = 13,
   parameter int SUMW = 30,
   parameter int QW   = 15
) (
   input  logic          clk_norm,
   input  logic          rstn_norm,
   input  logic          start_norm,
   input  logic [DW-1:0] w11, w12, w13, w14, w21, w22, w23, w24,
   input  logic [DW-1:0] w31, w32, w33, w34, w41, w42, w43, w44,
   input  logic [DW-1:0] w11_2, w12_2, w13_2, w14_2, w21_2, w22_2, w23_2, w24_2,
   input  logic [DW-1:0] w31_2, w32_2, w33_2, w34_2, w41_2, w42_2, w43_2, w44_2,
   output logic          busy_norm,
   output logic          done_norm,
   output logic          zero_norm,
   output logic [DW-1:0] n11, n12, n13, n14, n21, n22, n23, n24,
   output logic [DW-1:0] n31, n32, n33, n34, n41, n42, n43, n44,
   output logic [DW-1:0] norm_out
);
   localparam int RTW  = (SUMW + FRAC + 1) / 2;
   localparam int RADW = 2 * RTW;
   localparam int SRW  = RTW + 4;
   localparam logic [DW-1:0] SQ_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [QW-1:0] Q_MAX  = '1;

   typedef enum logic [2:0] {IDLE, ACC, SQRT, DIV, DONE, LAST} state_t;

   state_t          state;
   logic [DW-1:0]   w_in [16];
   logic [DW-1:0]   sq_in [16];
   logic [DW-1:0]   w_r [16];
   logic [DW-1:0]   sq_r [16];
   logic [DW-1:0]   res_r [16];
   logic [DW-1:0]   n_r [16];
   logic [SUMW-1:0] s_acc, s_next;
   logic [DW-1:0]   sq_add;
   logic [RADW-1:0] rad;
   logic [SRW-1:0]  srem, srem_sh, srem_n;
   logic [RTW-1:0]  root, root_n;
   logic [4:0]      cnt;
   logic [3:0]      elem, bitc;
   logic [RTW-1:0]  drem, cur_rem, rem_n;
   logic [RTW:0]    trial;
   logic [QW-1:0]   dlo, cur_lo, dq, q_n, q_fin;
   logic            dsat, first, sat_n, ge;
   logic [DW-1:0]   w_c, abs_w, q_ext, res_val;
   logic [DW-3:0]   quarter;

   assign w_in[0]  = w11;  assign w_in[1]  = w12;  assign w_in[2]  = w13;  assign w_in[3]  = w14;
   assign w_in[4]  = w21;  assign w_in[5]  = w22;  assign w_in[6]  = w23;  assign w_in[7]  = w24;
   assign w_in[8]  = w31;  assign w_in[9]  = w32;  assign w_in[10] = w33;  assign w_in[11] = w34;
   assign w_in[12] = w41;  assign w_in[13] = w42;  assign w_in[14] = w43;  assign w_in[15] = w44;
   assign sq_in[0]  = w11_2;  assign sq_in[1]  = w12_2;  assign sq_in[2]  = w13_2;  assign sq_in[3]  = w14_2;
   assign sq_in[4]  = w21_2;  assign sq_in[5]  = w22_2;  assign sq_in[6]  = w23_2;  assign sq_in[7]  = w24_2;
   assign sq_in[8]  = w31_2;  assign sq_in[9]  = w32_2;  assign sq_in[10] = w33_2;  assign sq_in[11] = w34_2;
   assign sq_in[12] = w41_2;  assign sq_in[13] = w42_2;  assign sq_in[14] = w43_2;  assign sq_in[15] = w44_2;
   assign n11 = n_r[0];   assign n12 = n_r[1];   assign n13 = n_r[2];   assign n14 = n_r[3];
   assign n21 = n_r[4];   assign n22 = n_r[5];   assign n23 = n_r[6];   assign n24 = n_r[7];
   assign n31 = n_r[8];   assign n32 = n_r[9];   assign n33 = n_r[10];  assign n34 = n_r[11];
   assign n41 = n_r[12];  assign n42 = n_r[13];  assign n43 = n_r[14];  assign n44 = n_r[15];

   always_comb begin
      // A negative square means the multiplier overflowed; count it as the largest positive value
      sq_add = sq_r[cnt[3:0]];
      if (sq_add[DW-1]) sq_add = SQ_MAX;
      s_next = s_acc + {{(SUMW-DW){1'b0}}, sq_add};

      srem_sh = (srem << 2) | SRW'(rad[RADW-1 -: 2]);
      srem_n  = srem[SRW-1] ? srem_sh + {{(SRW-RTW-2){1'b0}}, root, 2'b11}
                            : srem_sh - {{(SRW-RTW-2){1'b0}}, root, 2'b01};
      root_n  = (root << 1) | RTW'(!srem_n[SRW-1]);

      // Dividend |w|<<FRAC: its top part |w|>>2 seeds the remainder, the rest is fed in bitwise
      w_c     = w_r[elem];
      abs_w   = w_c[DW-1] ? (~w_c) + DW'(1) : w_c;
      quarter = abs_w[DW-1:2];
      first   = (bitc == 4'd0);
      cur_rem = first ? quarter[RTW-1:0] : drem;
      cur_lo  = first ? {abs_w[1:0], {FRAC{1'b0}}} : dlo;
      sat_n   = first ? (quarter >= (DW-2)'(root)) : dsat;
      trial   = {cur_rem, cur_lo[QW-1]};
      ge      = (trial >= {1'b0, root});
      rem_n   = ge ? RTW'(trial - {1'b0, root}) : trial[RTW-1:0];
      q_n     = (first ? '0 : (dq << 1)) | QW'(ge);
      q_fin   = sat_n ? Q_MAX : q_n;
`ifdef SYMM_NORM_ROUND_EN
      if (!sat_n && ({rem_n, 1'b0} >= {1'b0, root}) && (q_fin != Q_MAX)) q_fin = q_fin + QW'(1);
`endif
      q_ext   = {{(DW-QW){1'b0}}, q_fin};
      res_val = w_c[DW-1] ? (~q_ext) + DW'(1) : q_ext;
   end

   always_ff @(posedge clk_norm) begin
      if (!rstn_norm) begin
         state     <= IDLE;
         busy_norm <= 1'b0;
         done_norm <= 1'b0;
         zero_norm <= 1'b0;
         norm_out  <= '0;
         for (int i = 0; i < 16; i++) n_r[i] <= '0;
      end else begin
         case (state)
            IDLE: if (start_norm) begin
               for (int i = 0; i < 16; i++) begin
                  w_r[i]  <= w_in[i];
                  sq_r[i] <= sq_in[i];
               end
               s_acc     <= '0;
               cnt       <= '0;
               busy_norm <= 1'b1;
               state     <= ACC;
            end
            ACC: begin
               s_acc <= s_next;
               cnt   <= cnt + 5'd1;
               if (cnt == 5'd15) begin
                  cnt   <= '0;
                  rad   <= RADW'({s_next, {FRAC{1'b0}}});
                  srem  <= '0;
                  root  <= '0;
                  state <= (s_next == '0) ? DONE : SQRT;
               end
            end
            SQRT: begin
               srem <= srem_n;
               root <= root_n;
               rad  <= rad << 2;
               cnt  <= cnt + 5'd1;
               if (cnt == 5'(RTW-1)) begin
                  elem  <= '0;
                  bitc  <= '0;
                  state <= DIV;
               end
            end
            DIV: begin
               drem <= rem_n;
               dlo  <= cur_lo << 1;
               dq   <= q_n;
               dsat <= sat_n;
               if (bitc == 4'(QW-1)) begin
                  res_r[elem] <= res_val;
                  bitc        <= '0;
                  elem        <= elem + 4'd1;
                  if (elem == 4'd15) state <= DONE;
               end else begin
                  bitc <= bitc + 4'd1;
               end
            end
            DONE: begin
               done_norm <= 1'b1;
               zero_norm <= (s_acc == '0);
               norm_out  <= {{(DW-RTW){1'b0}}, root};
               for (int i = 0; i < 16; i++) n_r[i] <= (s_acc == '0) ? w_r[i] : res_r[i];
               state     <= LAST;
            end
            LAST: begin
               done_norm <= 1'b0;
               busy_norm <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_symm_norm.sv
// Directed bench for symm_norm: driver queues expected results at accept, a done_norm monitor checks them.
module tb_symm_norm;
   localparam int DW = 26;
`ifdef SYMM_NORM_ROUND_EN
   localparam logic [DW-1:0] RND = 26'd1;
`else
   localparam logic [DW-1:0] RND = 26'd0;
`endif

   typedef struct packed {
      logic [15:0][DW-1:0] n;
      logic [DW-1:0]       norm;
      logic                zero;
      logic [31:0]         t0;
      logic [31:0]         lat;
   } exp_t;

   logic          clk_norm = 1'b0;
   logic          rstn_norm = 1'b0;
   logic          start_norm = 1'b0;
   logic [DW-1:0] w_i [16];
   logic [DW-1:0] s_i [16];
   logic [DW-1:0] n_o [16];
   logic          busy_norm, done_norm, zero_norm;
   logic [DW-1:0] norm_out;
   logic [31:0]   cyc = 0;
   int            checks = 0, errors = 0, done_cnt = 0, exp_done = 0;
   exp_t          q[$];
   exp_t          mon_e;

   always #5 clk_norm = ~clk_norm;
   always @(posedge clk_norm) cyc <= cyc + 1;

   symm_norm dut (
      .clk_norm(clk_norm), .rstn_norm(rstn_norm), .start_norm(start_norm),
      .w11(w_i[0]),  .w12(w_i[1]),  .w13(w_i[2]),  .w14(w_i[3]),
      .w21(w_i[4]),  .w22(w_i[5]),  .w23(w_i[6]),  .w24(w_i[7]),
      .w31(w_i[8]),  .w32(w_i[9]),  .w33(w_i[10]), .w34(w_i[11]),
      .w41(w_i[12]), .w42(w_i[13]), .w43(w_i[14]), .w44(w_i[15]),
      .w11_2(s_i[0]),  .w12_2(s_i[1]),  .w13_2(s_i[2]),  .w14_2(s_i[3]),
      .w21_2(s_i[4]),  .w22_2(s_i[5]),  .w23_2(s_i[6]),  .w24_2(s_i[7]),
      .w31_2(s_i[8]),  .w32_2(s_i[9]),  .w33_2(s_i[10]), .w34_2(s_i[11]),
      .w41_2(s_i[12]), .w42_2(s_i[13]), .w43_2(s_i[14]), .w44_2(s_i[15]),
      .busy_norm(busy_norm), .done_norm(done_norm), .zero_norm(zero_norm),
      .n11(n_o[0]),  .n12(n_o[1]),  .n13(n_o[2]),  .n14(n_o[3]),
      .n21(n_o[4]),  .n22(n_o[5]),  .n23(n_o[6]),  .n24(n_o[7]),
      .n31(n_o[8]),  .n32(n_o[9]),  .n33(n_o[10]), .n34(n_o[11]),
      .n41(n_o[12]), .n42(n_o[13]), .n43(n_o[14]), .n44(n_o[15]),
      .norm_out(norm_out)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) cyc=%0d", nm, act, act, exp, exp, cyc);
      end
   endtask

   always @(negedge clk_norm) begin
      if (done_norm) begin
         done_cnt++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=done expected=none cyc=%0d", cyc);
         end else begin
            mon_e = q.pop_front();
            chk("latency", cyc - mon_e.t0, mon_e.lat);
            chk("norm_out", 32'(norm_out), 32'(mon_e.norm));
            chk("zero_norm", 32'(zero_norm), 32'(mon_e.zero));
            for (int i = 0; i < 16; i++)
               chk($sformatf("n[%0d]", i), 32'(n_o[i]), 32'(mon_e.n[i]));
         end
      end
   end

   function automatic exp_t mk(input logic [DW-1:0] nrm, input logic z, input int lat);
      exp_t e;
      e      = '0;
      e.norm = nrm;
      e.zero = z;
      e.lat  = 32'(lat);
      return e;
   endfunction

   function automatic logic [DW-1:0] neg(input logic [DW-1:0] v);
      return (~v) + 26'd1;
   endfunction

   task automatic clear_in();
      for (int i = 0; i < 16; i++) begin
         w_i[i] = '0;
         s_i[i] = '0;
      end
   endtask

   task automatic set_identity(output exp_t e);
      clear_in();
      e = mk(26'd16384, 1'b0, 279);
      for (int i = 0; i < 16; i += 5) begin
         w_i[i] = 26'd8192;
         s_i[i] = 26'd8192;
         e.n[i] = 26'd4096;
      end
   endtask

   // Caller sits at a negedge; returns at the negedge after the accept edge.
   task automatic launch(input exp_t e);
      start_norm = 1'b1;
      @(posedge clk_norm);
      #1;
      e.t0 = cyc;
      q.push_back(e);
      exp_done++;
      @(negedge clk_norm);
      start_norm = 1'b0;
   endtask

   task automatic wait_all();
      int k;
      k = 0;
      while (q.size() != 0 && k < 400) begin
         @(negedge clk_norm);
         k++;
      end
      chk("run_completes", 32'(q.size()), 32'd0);
      q.delete();
      @(negedge clk_norm);
   endtask

   task automatic run(input exp_t e);
      launch(e);
      wait_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   k;
      clear_in();
      repeat (3) @(posedge clk_norm);
      @(negedge clk_norm);
      chk("rst_busy", 32'(busy_norm), 32'd0);
      chk("rst_done", 32'(done_norm), 32'd0);
      chk("rst_zero", 32'(zero_norm), 32'd0);
      chk("rst_norm", 32'(norm_out), 32'd0);
      chk("rst_n11", 32'(n_o[0]), 32'd0);
      chk("rst_n44", 32'(n_o[15]), 32'd0);
      rstn_norm = 1'b1;
      @(negedge clk_norm);

      // Identity with stray starts at E5 and E200 plus input changes after accept
      set_identity(e);
      launch(e);
      chk("busy_after_accept", 32'(busy_norm), 32'd1);
      repeat (4) @(negedge clk_norm);
      clear_in();
      start_norm = 1'b1;
      @(negedge clk_norm);
      start_norm = 1'b0;
      repeat (194) @(negedge clk_norm);
      start_norm = 1'b1;
      @(negedge clk_norm);
      start_norm = 1'b0;
      k = 0;
      while (!done_norm && k < 200) begin
         @(negedge clk_norm);
         k++;
      end
      chk("done_seen", 32'(done_norm), 32'd1);
      chk("busy_during_done", 32'(busy_norm), 32'd1);

      // Back-to-back start in the cycle after done_norm
      @(negedge clk_norm);
      chk("busy_after_done", 32'(busy_norm), 32'd0);
      clear_in();
      w_i[0] = 26'd8192; w_i[1] = 26'd8192;
      s_i[0] = 26'd8192; s_i[1] = 26'd8192;
      e = mk(26'd11585, 1'b0, 279);
      e.n[0] = 26'd5792 + RND;
      e.n[1] = 26'd5792 + RND;
      launch(e);
      chk("busy_b2b", 32'(busy_norm), 32'd1);
      wait_all();

      clear_in();
      w_i[0] = neg(26'd8192); s_i[0] = 26'd8192;
      e = mk(26'd8192, 1'b0, 279);
      e.n[0] = neg(26'd8192);
      run(e);

      clear_in();
      w_i[0] = 26'd8192; w_i[1] = neg(26'd8192);
      s_i[0] = 26'd8192; s_i[1] = 26'd8192;
      e = mk(26'd11585, 1'b0, 279);
      e.n[0] = 26'd5792 + RND;
      e.n[1] = neg(26'd5792 + RND);
      run(e);

      clear_in();
      e = mk(26'd0, 1'b1, 17);
      run(e);

      clear_in();
      w_i[0] = 26'd123; w_i[6] = neg(26'd7);
      e = mk(26'd0, 1'b1, 17);
      e.n[0] = 26'd123;
      e.n[6] = neg(26'd7);
      run(e);

      clear_in();
      w_i[0] = 26'd8192; s_i[0] = 26'd1;
      e = mk(26'd90, 1'b0, 279);
      e.n[0] = 26'd32767;
      run(e);

      clear_in();
      w_i[0] = neg(26'd8192); s_i[0] = 26'd1;
      e = mk(26'd90, 1'b0, 279);
      e.n[0] = neg(26'd32767);
      run(e);

      // Negative square clamps to 2^25-1: root = floor(sqrt((2^25-1)*2^13)) = 524287
      clear_in();
      w_i[0] = 26'd8192; s_i[0] = '1;
      e = mk(26'd524287, 1'b0, 279);
      e.n[0] = 26'd128;
      run(e);

      // Reset at E100 aborts the run; nothing may be reported for it
      set_identity(e);
      launch(e);
      repeat (99) @(negedge clk_norm);
      rstn_norm = 1'b0;
      void'(q.pop_back());
      exp_done--;
      @(negedge clk_norm);
      chk("abort_busy", 32'(busy_norm), 32'd0);
      chk("abort_done", 32'(done_norm), 32'd0);
      chk("abort_zero", 32'(zero_norm), 32'd0);
      chk("abort_norm", 32'(norm_out), 32'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("abort_n[%0d]", i), 32'(n_o[i]), 32'd0);
      rstn_norm = 1'b1;
      repeat (300) @(negedge clk_norm);
      set_identity(e);
      run(e);

      chk("done_count", 32'(done_cnt), 32'(exp_done));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
